// File: rtl/serial_rx_sequencer_if.sv
// Character handshake between the serial receiver and its downstream consumer.
interface serial_rx_sequencer_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] char_data;
  logic                 char_valid;
  logic                 char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/serial_rx_sequencer.sv
// Oversampled serial receive controller: start qualification, mid-bit sampling,
// character holding register with valid/ready, framing/overrun flags.
// Optional even parity bit and parity_err port when SERIAL_RX_PARITY_EN is defined.
module serial_rx_sequencer #(
  parameter int   DATA_BITS   = 8,
  parameter int   OVERSAMPLE  = 16,
  parameter logic START_LEVEL = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          serial_in,
  input  logic                          rx_enable,
  input  logic                          clear_err,
  serial_rx_sequencer_if.master         rx_if,
  output logic                          busy,
  output logic                          framing_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_LOAD
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  logic line;
  logic handshake;

  assign line      = sync_q[1];
  assign handshake = valid_q & rx_if.char_ready;

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], serial_in};
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d  = 1'b0;
`endif

    if (handshake) valid_d = 1'b0;
    if (clear_err) ovr_d = 1'b0;

    if (!rx_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (line == START_LEVEL) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (line == START_LEVEL) ? S_DATA : S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_d          = '0;
            shift_d[idx_q] = line;
            if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (line == ^shift_q) begin
              state_d = S_STOP;
            end else begin
              perr_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (line == ~START_LEVEL) begin
              state_d = S_LOAD;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_LOAD: begin
          // A consumer taking the old char this very cycle frees the register.
          if (!valid_q || handshake) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync_q  <= {2{~START_LEVEL}};
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_if.char_data  = data_q;
  assign rx_if.char_valid = valid_q;
  assign busy             = busy_q;
  assign framing_err      = ferr_q;
  assign overrun          = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err       = perr_q;
`endif

endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Scoreboard bench for serial_rx_sequencer: expected chars are queued as frames
// are driven and popped by a monitor on each valid/ready acceptance.
module tb_serial_rx_sequencer;
  localparam int   DATA_BITS   = 8;
  localparam int   OVERSAMPLE  = 16;
  localparam logic START_LEVEL = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
  localparam int PAR_CLKS = OVERSAMPLE;
`else
  localparam bit USE_PAR = 1'b0;
  localparam int PAR_CLKS = 0;
`endif
  // Clocks from line at START_LEVEL to char_valid, plus two synchronizer stages.
  localparam int LATENCY   = OVERSAMPLE / 2 + (DATA_BITS + 1) * OVERSAMPLE + 2 + PAR_CLKS;
  localparam int DRIVE_LAT = LATENCY + 2;

  logic clock, reset, serial_in, rx_enable, clear_err;
  logic busy, framing_err, overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic parity_err;
`endif

  serial_rx_sequencer_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  serial_rx_sequencer #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .START_LEVEL(START_LEVEL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .serial_in  (serial_in),
    .rx_enable  (rx_enable),
    .clear_err  (clear_err),
    .rx_if      (rx_if),
    .busy       (busy),
    .framing_err(framing_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int rise_cyc  = -1;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  int busy_cnt  = 0;
  logic prev_valid = 1'b0;
  logic [DATA_BITS-1:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: counts pulses and checks every accepted char against the queue.
  initial begin
    logic [DATA_BITS-1:0] exp;
    forever begin
      @(negedge clock);
      if (rx_if.char_valid === 1'b1) begin
        valid_cnt++;
        if (prev_valid !== 1'b1) rise_cyc = cyc;
      end
      prev_valid = rx_if.char_valid;
      if (framing_err === 1'b1) ferr_cnt++;
      if (busy === 1'b1) busy_cnt++;
`ifdef SERIAL_RX_PARITY_EN
      if (parity_err === 1'b1) perr_cnt++;
`endif
      if (rx_if.char_valid === 1'b1 && rx_if.char_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL accept_unexpected got=%h required=none", rx_if.char_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_if.char_data !== exp) begin
            bad++;
            $display("FAIL accept_data got=%h required=%h", rx_if.char_data, exp);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_ok, input bit par_ok);
    start_cyc = cyc;
    serial_in = START_LEVEL;
    tick(OVERSAMPLE);
    for (int i = 0; i < DATA_BITS; i++) begin
      serial_in = d[i];
      tick(OVERSAMPLE);
    end
    if (USE_PAR) begin
      serial_in = par_ok ? (^d) : ~(^d);
      tick(OVERSAMPLE);
    end
    serial_in = stop_ok ? ~START_LEVEL : START_LEVEL;
    tick(OVERSAMPLE);
    serial_in = ~START_LEVEL;
  endtask

  task automatic test_reset();
    reset = 1'b0; serial_in = ~START_LEVEL; rx_enable = 1'b1;
    clear_err = 1'b0; rx_if.char_ready = 1'b1;
    tick(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
    total++; if (rx_if.char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b required=0", rx_if.char_valid); end
    total++; if (rx_if.char_data !== '0) begin bad++; $display("FAIL reset_data got=%h required=0", rx_if.char_data); end
    total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b required=0", framing_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b required=0", overrun); end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(20);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_drained got=%0d required=0", exp_q.size()); end
    total++; if (rise_cyc - start_cyc != DRIVE_LAT) begin bad++; $display("FAIL basic_latency got=%0d required=%0d", rise_cyc - start_cyc, DRIVE_LAT); end
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL basic_valid_width got=%0d required=1", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 != 0) begin bad++; $display("FAIL basic_ferr got=%0d required=0", ferr_cnt - f0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b required=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b required=0", busy); end
  endtask

  task automatic test_glitch();
    int b0 = busy_cnt;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    serial_in = START_LEVEL;
    tick(5);
    serial_in = ~START_LEVEL;
    tick(30);
    total++; if ((busy_cnt > b0) !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen got=0 required=1"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b required=0", busy); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL glitch_valid got=%0d required=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 != 0) begin bad++; $display("FAIL glitch_ferr got=%0d required=0", ferr_cnt - f0); end
  endtask

  task automatic test_framing();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(20);
    total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL framing_pulse got=%0d required=1", ferr_cnt - f0); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL framing_valid got=%0d required=0", valid_cnt - v0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL framing_busy got=%b required=0", busy); end
  endtask

  task automatic test_overrun();
    rx_if.char_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(5);
    total++; if (rx_if.char_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b required=1", rx_if.char_valid); end
    total++; if (rx_if.char_data !== 8'h11) begin bad++; $display("FAIL ovr_held got=%h required=11", rx_if.char_data); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b required=1", overrun); end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b required=0", overrun); end
    rx_if.char_ready = 1'b1;
    tick(3);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovr_drained got=%0d required=0", exp_q.size()); end
    total++; if (rx_if.char_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_clr got=%b required=0", rx_if.char_valid); end
  endtask

  task automatic test_abort_reset();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        tick(OVERSAMPLE + 4 * OVERSAMPLE + OVERSAMPLE / 2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b required=1", busy); end
        rx_enable = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b required=0", busy); end
      end
    join
    tick(10);
    rx_enable = 1'b1;
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL abort_valid got=%0d required=0", valid_cnt - v0); end
    total++; if (ferr_cnt - f0 != 0) begin bad++; $display("FAIL abort_ferr got=%0d required=0", ferr_cnt - f0); end
    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        tick(60);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b required=1", busy); end
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
        total++; if (rx_if.char_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", rx_if.char_valid); end
        total++; if (rx_if.char_data !== '0) begin bad++; $display("FAIL rst_data got=%h required=0", rx_if.char_data); end
        total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b required=0", framing_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b required=0", overrun); end
      end
    join
    tick(3);
    reset = 1'b1;
    tick(5);
    v0 = valid_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(20);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_rst_drained got=%0d required=0", exp_q.size()); end
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL post_rst_valid got=%0d required=1", valid_cnt - v0); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int v0;
    int p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL par_ok_drained got=%0d required=0", exp_q.size()); end
    total++; if (perr_cnt - p0 != 0) begin bad++; $display("FAIL par_ok_perr got=%0d required=0", perr_cnt - p0); end
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    total++; if (perr_cnt - p0 != 1) begin bad++; $display("FAIL par_bad_perr got=%0d required=1", perr_cnt - p0); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL par_bad_valid got=%0d required=0", valid_cnt - v0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_abort_reset();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
